dmem_responder: RTL and testbench

//  Data-memory responder on the far side of the execute stage's load/store interface.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Access-width encodings, FSM states and the captured request bundle.
package dmem_pkg;

  localparam logic [31:0] W_BYTE = 32'd1;
  localparam logic [31:0] W_HALF = 32'd2;
  localparam logic [31:0] W_WORD = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] width;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for 1/2/4-byte accesses into a 32-bit word.
// Ports: width, lane, wdata, rword in; be, wdata_sh, rdata, bad_width, misalign out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] width,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        bad_width,
  output logic        misalign
);

  logic [31:0] rmask;
  logic [4:0]  sh;

  assign sh = {lane, 3'b000};

  always_comb begin
    be        = '0;
    rmask     = '0;
    bad_width = 1'b0;
    misalign  = 1'b0;
    unique case (1'b1)
      (width == W_BYTE): begin
        be    = 4'b0001 << lane;
        rmask = 32'h0000_00ff;
      end
      (width == W_HALF): begin
        be       = 4'b0011 << lane;
        rmask    = 32'h0000_ffff;
        misalign = lane[0];
      end
      (width == W_WORD): begin
        be       = 4'b1111 << lane;
        rmask    = 32'hffff_ffff;
        misalign = |lane;
      end
      default: bad_width = 1'b1;
    endcase
  end

  assign wdata_sh = wdata << sh;
  assign rdata    = (rword >> sh) & rmask;

endmodule

// File: rtl/dmem_responder.sv
// Serial data-memory responder: one request at a time, fixed latency.
// Ports: clk, rst_n, req_* (valid/ready/addr/we/width/wdata), rsp_* (valid/ready/rdata/err).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_width,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT =
    {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  state_t      state;
  dmem_req_t   req;
  logic [CW-1:0] cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ld_data;
  logic          bad_width;
  logic          misalign;
  logic          oor;
  logic          err;
  logic          do_access;

  // 33-bit compare so the top of the map never wraps to zero.
  assign oor = ({1'b0, req.addr} < {1'b0, BASE_ADDR})
             || ({1'b0, req.addr} >= LIMIT);

  assign idx = IW'(({1'b0, req.addr}
             - {1'b0, BASE_ADDR}) >> 2);

  assign rword     = mem[idx];
  assign err       = bad_width | misalign | oor;
  assign do_access = (state == WAIT) && (cnt == '0);
  assign req_ready = (state == IDLE);

  dmem_lane_align u_align (
    .width     (req.width),
    .lane      (req.addr[1:0]),
    .wdata     (req.wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata     (ld_data),
    .bad_width (bad_width),
    .misalign  (misalign)
  );

  // Contents survive reset; an async reset forces IDLE so
  // an in-flight store never reaches its write edge.
  always_ff @(posedge clk) begin
    if (do_access && !err && req.we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req.addr  <= req_addr;
            req.we    <= req_we;
            req.width <= req_width;
            req.wdata <= req_wdata;
            cnt       <= CW'(LATENCY - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || req.we) ? '0 : ld_data;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Directed requests push expectations; a monitor checks each response.
module tb_dmem_responder;

  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_width;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_width (req_width),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;

  logic [31:0] p_rdata;
  logic        p_err;
  logic        prev_v;
  logic [31:0] held_r;
  logic        held_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Accept observer: one expectation per accepted request.
  always @(posedge clk) begin : acc_blk
    exp_t e;
    if (rst_n && req_valid && req_ready) begin
      e.rdata = p_rdata;
      e.err   = p_err;
      e.acc   = cyc + 1;
      q.push_back(e);
      acc_cnt++;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!prev_v) begin
        held_r = rsp_rdata;
        held_e = rsp_err;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %h",
                   rsp_rdata);
        end else begin
          chk("latency", cyc - q[0].acc, LAT);
        end
      end else begin
        chk("stable_rdata", rsp_rdata, held_r);
        chk("stable_err", {31'b0, rsp_err},
            {31'b0, held_e});
      end
      if (!rsp_ready) begin
        chk("req_ready_busy", {31'b0, req_ready}, 0);
      end
      if (rsp_ready && q.size() > 0) begin
        chk("rdata", rsp_rdata, q[0].rdata);
        chk("err", {31'b0, rsp_err},
            {31'b0, q[0].err});
        void'(q.pop_front());
      end
    end
    prev_v = rst_n && rsp_valid;
  end

  task automatic issue(input logic [31:0] a,
                       input logic w,
                       input logic [31:0] wd,
                       input logic [31:0] d,
                       input logic [31:0] er,
                       input logic ee,
                       input bit hold);
    int start;
    int n;
    start     = acc_cnt;
    n         = 0;
    p_rdata   = er;
    p_err     = ee;
    req_addr  = a;
    req_we    = w;
    req_width = wd;
    req_wdata = d;
    req_valid = 1'b1;
    while (acc_cnt == start && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_cnt == start) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: addr %h", a);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic op(input logic [31:0] a,
                    input logic w,
                    input logic [31:0] wd,
                    input logic [31:0] d,
                    input logic [31:0] er,
                    input logic ee);
    issue(a, w, wd, d, er, ee, 1'b0);
    drain();
  endtask

  int acc0;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_width = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    p_rdata   = '0;
    p_err     = 1'b0;
    prev_v    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", {31'b0, rsp_err}, 0);
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: word store and load
    op(BASE, 1, 4, 32'hDEAD_BEEF, 0, 0);
    op(BASE, 0, 4, 0, 32'hDEAD_BEEF, 0);

    // 2: byte/half lanes; upper wdata bits must be ignored
    op(BASE + 3, 1, 1, 32'hFFFF_FFAB, 0, 0);
    op(BASE, 0, 4, 0, 32'hABAD_BEEF, 0);
    op(BASE + 3, 0, 1, 0, 32'h0000_00AB, 0);
    op(BASE + 2, 0, 2, 0, 32'h0000_ABAD, 0);
    op(BASE + 1, 0, 1, 0, 32'h0000_00BE, 0);
    op(BASE + 4, 1, 4, 32'h1122_3344, 0, 0);
    op(BASE + 6, 1, 2, 32'h9999_CAFE, 0, 0);
    op(BASE + 4, 0, 4, 0, 32'hCAFE_3344, 0);

    // 3: alignment and width errors
    op(BASE + 1, 1, 2, 32'h5555, 0, 1);
    op(BASE, 0, 4, 0, 32'hABAD_BEEF, 0);
    op(BASE, 0, 3, 0, 0, 1);
    op(BASE + 2, 0, 4, 0, 0, 1);
    op(BASE + 1, 0, 2, 0, 0, 1);
    op(BASE + 4, 0, 0, 0, 0, 1);

    // 4: address range edges
    op(32'h7FFF_FFFC, 0, 4, 0, 0, 1);
    op(BASE + 4 * DEPTH, 0, 4, 0, 0, 1);
    op(32'hFFFF_FFFC, 0, 4, 0, 0, 1);
    op(BASE + 4 * DEPTH - 4, 1, 4, 32'h0F0F_0F0F, 0, 0);
    op(BASE + 4 * DEPTH - 4, 0, 4, 0, 32'h0F0F_0F0F, 0);

    // 5: backpressure with req_valid held high
    rsp_ready = 1'b0;
    acc0 = acc_cnt;
    issue(BASE, 0, 4, 0, 32'hABAD_BEEF, 0, 1'b1);
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
    end
    chk("single_accept", acc_cnt, acc0 + 1);
    chk("hold_valid", {31'b0, rsp_valid}, 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // 6: reset during WAIT drops the store
    op(BASE, 1, 4, 32'hDEAD_BEEF, 0, 0);
    issue(BASE, 1, 4, 32'h1234_5678, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, rsp_valid}, 0);
    chk("midrst_ready", {31'b0, req_ready}, 1);
    q.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_hold", {31'b0, rsp_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op(BASE, 0, 4, 0, 32'hDEAD_BEEF, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
